// File: rtl/dap_resp_packer.sv
// Frames the DAP response byte stream into length-delimited packets and replays
// each packet as an AXI-Stream burst (tlast on the final byte) for the USB IN endpoint.
module dap_resp_packer #(
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned LEN_AW  = 3,
    parameter int unsigned PKT_MAX = 64
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              en,
    input  logic              in_tvalid,
    input  logic [7:0]        in_tdata,
    input  logic              in_flush,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [7:0]        m_tdata,
    output logic              m_tlast,
    output logic [ADDR_W:0]   free_bytes,
    output logic [LEN_AW:0]   pkt_pending,
    output logic              overflow
);

    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned LDEPTH = 2 ** LEN_AW;
    localparam logic [ADDR_W:0] DEPTH_W = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] PKT_MAX_W = (ADDR_W + 1)'(PKT_MAX);
    localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

    state_t           state;
    logic [7:0]       mem  [DEPTH];
    logic [ADDR_W:0]  lmem [LDEPTH];
    logic [7:0]       ram_q;
    logic [ADDR_W:0]  wr_ptr, rd_ptr, rd_addr;
    logic [LEN_AW:0]  lwr, lrd;
    logic [ADDR_W:0]  open_cnt, cnt_next, rem_cnt;
    logic             bfull, lfull, lempty;
    logic             byte_acc, close_max, flush_want, push_len, drop, hs, last_hs;

    assign bfull  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                    (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign lfull  = (lwr[LEN_AW] != lrd[LEN_AW]) &&
                    (lwr[LEN_AW-1:0] == lrd[LEN_AW-1:0]);
    assign lempty = (lwr == lrd);

    assign byte_acc   = en && in_tvalid && !bfull && !lfull;
    assign cnt_next   = open_cnt + (ADDR_W + 1)'(byte_acc);
    assign close_max  = byte_acc && (cnt_next == PKT_MAX_W);
    assign flush_want = en && in_flush && (cnt_next != '0);
    assign push_len   = close_max || (flush_want && !lfull);
    assign drop       = (en && in_tvalid && !byte_acc) || (flush_want && lfull);
    assign hs         = m_tvalid && m_tready;
    assign last_hs    = hs && m_tlast;

    assign free_bytes = DEPTH_W - (wr_ptr - rd_ptr);

    // ram_q always holds the byte one past the one on m_tdata, so a handshake
    // can present the next byte without a bubble.
    always_comb begin
        rd_addr = rd_ptr;
        case (state)
            IDLE:    rd_addr = rd_ptr;
            LOAD:    rd_addr = rd_ptr + ONE;
            default: rd_addr = hs ? rd_ptr + (ADDR_W + 1)'(2) : rd_ptr + ONE;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (byte_acc)
            mem[wr_ptr[ADDR_W-1:0]] <= in_tdata;
        if (push_len)
            lmem[lwr[LEN_AW-1:0]] <= cnt_next;
        ram_q <= mem[rd_addr[ADDR_W-1:0]];
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            lwr         <= '0;
            lrd         <= '0;
            open_cnt    <= '0;
            rem_cnt     <= '0;
            pkt_pending <= '0;
            overflow    <= 1'b0;
            m_tvalid    <= 1'b0;
            m_tdata     <= '0;
            m_tlast     <= 1'b0;
        end else if (!en) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            lwr         <= '0;
            lrd         <= '0;
            open_cnt    <= '0;
            rem_cnt     <= '0;
            pkt_pending <= '0;
            overflow    <= 1'b0;
            m_tvalid    <= 1'b0;
            m_tdata     <= '0;
            m_tlast     <= 1'b0;
        end else begin
            if (byte_acc)
                wr_ptr <= wr_ptr + ONE;
            if (push_len)
                lwr <= lwr + (LEN_AW + 1)'(1);
            open_cnt <= push_len ? '0 : cnt_next;
            if (drop)
                overflow <= 1'b1;

            case ({push_len, last_hs})
                2'b10:   pkt_pending <= pkt_pending + (LEN_AW + 1)'(1);
                2'b01:   pkt_pending <= pkt_pending - (LEN_AW + 1)'(1);
                default: pkt_pending <= pkt_pending;
            endcase

            case (state)
                IDLE: begin
                    if (!lempty) begin
                        rem_cnt <= lmem[lrd[LEN_AW-1:0]];
                        lrd     <= lrd + (LEN_AW + 1)'(1);
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    m_tvalid <= 1'b1;
                    m_tdata  <= ram_q;
                    m_tlast  <= (rem_cnt == ONE);
                    state    <= SEND;
                end
                default: begin
                    if (hs) begin
                        rd_ptr <= rd_ptr + ONE;
                        if (m_tlast) begin
                            m_tvalid <= 1'b0;
                            m_tlast  <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            m_tdata <= ram_q;
                            m_tlast <= (rem_cnt == (ADDR_W + 1)'(2));
                            rem_cnt <= rem_cnt - ONE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dap_resp_packer.sv
// Directed bench for dap_resp_packer: a packet-level model tracks stored bytes,
// queued beats, pending packets and overflow; the DUT is compared every cycle.
module tb_dap_resp_packer;

    localparam int ADDR_W  = 9;
    localparam int LEN_AW  = 3;
    localparam int PKT_MAX = 64;
    localparam int DEPTH   = 2 ** ADDR_W;

    logic              hclk = 1'b0;
    logic              hresetn = 1'b0;
    logic              en = 1'b0;
    logic              in_tvalid = 1'b0;
    logic [7:0]        in_tdata = '0;
    logic              in_flush = 1'b0;
    logic              m_tvalid;
    logic              m_tready = 1'b0;
    logic [7:0]        m_tdata;
    logic              m_tlast;
    logic [ADDR_W:0]   free_bytes;
    logic [LEN_AW:0]   pkt_pending;
    logic              overflow;

    always #5 hclk = ~hclk;

    dap_resp_packer #(.ADDR_W(ADDR_W), .LEN_AW(LEN_AW), .PKT_MAX(PKT_MAX)) dut (
        .hclk(hclk), .hresetn(hresetn), .en(en),
        .in_tvalid(in_tvalid), .in_tdata(in_tdata), .in_flush(in_flush),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
        .free_bytes(free_bytes), .pkt_pending(pkt_pending), .overflow(overflow)
    );

    int passes = 0;
    int total  = 0;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // Model state
    logic [7:0] exp_d[$];
    bit         exp_l[$];
    logic [7:0] open_q[$];
    logic [7:0] obs_d[$];
    bit         obs_l[$];
    int         m_stored = 0;
    int         m_pend   = 0;
    bit         m_ovf    = 1'b0;

    always @(negedge hclk) begin
        if (hresetn) begin
            bit hs, hs_last, acc;
            check("free_bytes", int'(free_bytes), DEPTH - m_stored);
            check("pkt_pending", int'(pkt_pending), m_pend);
            check("overflow", int'(overflow), int'(m_ovf));
            if (exp_d.size() == 0) begin
                check("idle_valid", int'(m_tvalid), 0);
            end else if (m_tvalid) begin
                check("beat_data", int'(m_tdata), int'(exp_d[0]));
                check("beat_last", int'(m_tlast), int'(exp_l[0]));
            end
            hs = en && m_tvalid && m_tready && (exp_d.size() != 0);
            hs_last = 1'b0;
            if (hs) begin
                obs_d.push_back(exp_d[0]);
                obs_l.push_back(exp_l[0]);
                hs_last = exp_l[0];
                void'(exp_d.pop_front());
                void'(exp_l.pop_front());
            end
            if (!en) begin
                exp_d.delete(); exp_l.delete(); open_q.delete();
                m_stored = 0; m_pend = 0; m_ovf = 1'b0;
            end else begin
                acc = 1'b0;
                if (in_tvalid) begin
                    if (m_stored < DEPTH) begin
                        acc = 1'b1;
                        open_q.push_back(in_tdata);
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
                if (hs) m_stored--;
                if (hs_last) m_pend--;
                if (acc) m_stored++;
                if ((acc && open_q.size() == PKT_MAX) || (in_flush && open_q.size() > 0)) begin
                    for (int i = 0; i < open_q.size(); i++) begin
                        exp_d.push_back(open_q[i]);
                        exp_l.push_back(i == open_q.size() - 1);
                    end
                    open_q.delete();
                    m_pend++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input bit fl);
        in_tvalid = 1'b1;
        in_tdata  = d;
        in_flush  = fl;
        tick();
        in_tvalid = 1'b0;
        in_flush  = 1'b0;
    endtask

    task automatic flush();
        in_flush = 1'b1;
        tick();
        in_flush = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        while ((exp_d.size() != 0 || m_tvalid) && n < max_cycles) begin
            tick();
            n++;
        end
        check("drain_timeout", exp_d.size(), 0);
    endtask

    task automatic clear_obs();
        obs_d.delete();
        obs_l.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", passes, total);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge hclk);
        #1;
        check("rst_free", int'(free_bytes), DEPTH);
        check("rst_pend", int'(pkt_pending), 0);
        check("rst_ovf", int'(overflow), 0);
        check("rst_valid", int'(m_tvalid), 0);
        check("rst_last", int'(m_tlast), 0);
        check("rst_data", int'(m_tdata), 0);
        hresetn = 1'b1;
        en = 1'b1;
        m_tready = 1'b1;
        tick();

        // T1: three bytes then flush, with close-to-valid latency
        clear_obs();
        send_byte(8'h05, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hAA, 1'b0);
        flush();
        check("t1_lat_n", int'(m_tvalid), 0);
        tick();
        check("t1_lat_n1", int'(m_tvalid), 0);
        tick();
        check("t1_lat_n2", int'(m_tvalid), 1);
        check("t1_pend1", int'(pkt_pending), 1);
        drain(50);
        check("t1_beats", obs_d.size(), 3);
        check("t1_d0", int'(obs_d[0]), 8'h05);
        check("t1_d1", int'(obs_d[1]), 8'h00);
        check("t1_d2", int'(obs_d[2]), 8'hAA);
        check("t1_l1", int'(obs_l[1]), 0);
        check("t1_l2", int'(obs_l[2]), 1);
        check("t1_pend0", int'(pkt_pending), 0);

        // T2: 130 bytes with no flush, then flush the 2-byte tail
        clear_obs();
        for (int i = 0; i < 130; i++) send_byte(8'(i), 1'b0);
        drain(300);
        check("t2_beats", obs_d.size(), 128);
        check("t2_d63", int'(obs_d[63]), 8'h3F);
        check("t2_l62", int'(obs_l[62]), 0);
        check("t2_l63", int'(obs_l[63]), 1);
        check("t2_d127", int'(obs_d[127]), 8'h7F);
        check("t2_l127", int'(obs_l[127]), 1);
        check("t2_held", int'(free_bytes), DEPTH - 2);
        flush();
        drain(50);
        check("t2_tail_beats", obs_d.size(), 130);
        check("t2_d128", int'(obs_d[128]), 8'h80);
        check("t2_l128", int'(obs_l[128]), 0);
        check("t2_d129", int'(obs_d[129]), 8'h81);
        check("t2_l129", int'(obs_l[129]), 1);

        // T3: flush coincident with the fifth byte
        clear_obs();
        send_byte(8'h10, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h13, 1'b0);
        send_byte(8'h7E, 1'b1);
        drain(50);
        check("t3_beats", obs_d.size(), 5);
        check("t3_l3", int'(obs_l[3]), 0);
        check("t3_d4", int'(obs_d[4]), 8'h7E);
        check("t3_l4", int'(obs_l[4]), 1);

        // T5: empty flush, then double flush after a 2-byte packet
        clear_obs();
        m_tready = 1'b0;
        flush();
        tick();
        check("t5_empty_flush", int'(pkt_pending), 0);
        send_byte(8'h21, 1'b0);
        send_byte(8'h22, 1'b0);
        flush();
        flush();
        tick();
        check("t5_double_flush", int'(pkt_pending), 1);
        m_tready = 1'b1;
        drain(50);
        check("t5_beats", obs_d.size(), 2);
        check("t5_l1", int'(obs_l[1]), 1);
        check("t5_pend0", int'(pkt_pending), 0);

        // T4: fill with ready low, last 3 bytes dropped, then drain
        clear_obs();
        m_tready = 1'b0;
        for (int i = 0; i < DEPTH + 3; i++) send_byte(8'(i), 1'b0);
        tick();
        check("t4_full", int'(free_bytes), 0);
        check("t4_ovf", int'(overflow), 1);
        check("t4_pend", int'(pkt_pending), DEPTH / PKT_MAX);
        m_tready = 1'b1;
        drain(2000);
        check("t4_beats", obs_d.size(), DEPTH);
        check("t4_d300", int'(obs_d[300]), 8'h2C);
        check("t4_d511", int'(obs_d[511]), 8'hFF);
        check("t4_l511", int'(obs_l[511]), 1);
        check("t4_ovf_sticky", int'(overflow), 1);

        // T6: en low during beat 10 of a 64-byte packet
        clear_obs();
        m_tready = 1'b0;
        for (int i = 0; i < PKT_MAX; i++) send_byte(8'(i + 8'h40), 1'b0);
        m_tready = 1'b1;
        begin
            int n = 0;
            while (obs_d.size() < 10 && n < 200) begin
                tick();
                n++;
            end
        end
        check("t6_beats_before", obs_d.size(), 10);
        check("t6_valid_before", int'(m_tvalid), 1);
        en = 1'b0;
        tick();
        check("t6_valid", int'(m_tvalid), 0);
        check("t6_last", int'(m_tlast), 0);
        check("t6_free", int'(free_bytes), DEPTH);
        check("t6_pend", int'(pkt_pending), 0);
        check("t6_ovf", int'(overflow), 0);
        en = 1'b1;
        tick();
        check("t6_free_after", int'(free_bytes), DEPTH);
        clear_obs();
        send_byte(8'h33, 1'b1);
        drain(50);
        check("t6_new_beats", obs_d.size(), 1);
        check("t6_new_d0", int'(obs_d[0]), 8'h33);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
